// File: rtl/bcd_cnt_2digit_pkg.sv
// Shared BCD types, digit limits and the nibble clamp used by the display counter.
package seg_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX_DIGIT = 4'd9;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef struct packed {
    bcd_t msd;
    bcd_t lsd;
  } bcd_pair_t;

  // Any non-decimal nibble (A-F) saturates to 9.
  function automatic bcd_t bcd_clamp(input bcd_t nibble);
    return (nibble > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : nibble;
  endfunction

endpackage

// File: rtl/bcd_cnt_2digit_if.sv
// Control and digit bus between the BCD counter and whoever drives/consumes it.
interface bcd_cnt_2digit_if;
  import seg_pkg::*;

  logic en;
  logic up;
  logic load;
  bcd_t load_lsd;
  bcd_t load_msd;
  bcd_t lsd;
  bcd_t msd;
  logic tick;
  logic wrap;

  modport master (
    output en, up, load, load_lsd, load_msd,
    input  lsd, msd, tick, wrap
  );

  modport slave (
    input  en, up, load, load_lsd, load_msd,
    output lsd, msd, tick, wrap
  );

endinterface

// File: rtl/bcd_cnt_2digit_bcd_digit.sv
// Single decade counter: load > inc > dec > hold; carry flags a 9->0 or 0->wrap_to roll.
module bcd_digit
  import seg_pkg::*;
(
  input  logic clock,
  input  logic resetn,
  input  logic inc,
  input  logic dec,
  input  logic ld,
  input  bcd_t ld_val,
  input  bcd_t wrap_to,
  output bcd_t val,
  output logic carry
);

  localparam bcd_t ONE = bcd_t'(1);

  assign carry = ~ld & ((inc & (val == BCD_MAX_DIGIT)) |
                        (~inc & dec & (val == '0)));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      val <= '0;
    end else if (ld) begin
      val <= ld_val;
    end else if (inc) begin
      val <= (val == BCD_MAX_DIGIT) ? '0 : val + ONE;
    end else if (dec) begin
      val <= (val == '0) ? wrap_to : val - ONE;
    end
  end

endmodule

// File: rtl/bcd_cnt_2digit.sv
// Two-digit BCD up/down counter with prescaler, clamped synchronous load and
// programmable terminal count; feeds the multiplexed 7-segment display stage.
module bcd_cnt_2digit
  import seg_pkg::*;
#(
  parameter int          DIV     = 50_000_000,
  parameter logic [7:0]  MAX_BCD = 8'h99
) (
  input  logic             clock,
  input  logic             resetn,
  bcd_cnt_2digit_if.slave  cnt
);

  localparam int             PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0]  PRE_ONE  = PW'(1);

  logic [PW-1:0] pre;
  logic          tick_q;
  logic          wrap_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pre    <= '0;
      tick_q <= 1'b0;
    end else begin
      pre    <= (pre == PRE_LAST) ? '0 : pre + PRE_ONE;
      tick_q <= (pre == PRE_LAST);
    end
  end

  bcd_t       lsd_v;
  bcd_t       msd_v;
  logic       lsd_carry;
  logic       msd_carry;
  logic [7:0] cur;
  logic       at_max;
  logic       at_zero;

  assign cur     = {msd_v, lsd_v};
  assign at_max  = (cur == MAX_BCD);
  assign at_zero = (cur == 8'h00);

  // Loads saturate per digit first, then the pair saturates at the terminal count.
  bcd_pair_t  clamp_pair;
  bcd_pair_t  ld_pair;
  assign clamp_pair.msd = bcd_clamp(cnt.load_msd);
  assign clamp_pair.lsd = bcd_clamp(cnt.load_lsd);
  assign ld_pair        = (clamp_pair > MAX_BCD) ? bcd_pair_t'(MAX_BCD) : clamp_pair;

  logic       step;
  logic       step_up;
  logic       step_dn;
  logic       wrap_evt;
  logic       digit_ld;
  bcd_pair_t  digit_val;

  assign step     = tick_q & cnt.en & ~cnt.load;
  assign step_up  = step & cnt.up;
  assign step_dn  = step & ~cnt.up;
  assign wrap_evt = (step_up & at_max) | (step_dn & at_zero);

  // Terminal-count wraps reuse the digits' load path rather than their carry chain.
  assign digit_ld  = cnt.load | wrap_evt;
  assign digit_val = cnt.load ? ld_pair :
                     (cnt.up ? bcd_pair_t'(8'h00) : bcd_pair_t'(MAX_BCD));

  bcd_digit u_lsd (
    .clock   (clock),
    .resetn  (resetn),
    .inc     (step_up & ~at_max),
    .dec     (step_dn & ~at_zero),
    .ld      (digit_ld),
    .ld_val  (digit_val.lsd),
    .wrap_to (BCD_MAX_DIGIT),
    .val     (lsd_v),
    .carry   (lsd_carry)
  );

  bcd_digit u_msd (
    .clock   (clock),
    .resetn  (resetn),
    .inc     (lsd_carry & cnt.up),
    .dec     (lsd_carry & ~cnt.up),
    .ld      (digit_ld),
    .ld_val  (digit_val.msd),
    .wrap_to (BCD_MAX_DIGIT),
    .val     (msd_v),
    .carry   (msd_carry)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_evt;
    end
  end

  assign cnt.lsd  = lsd_v;
  assign cnt.msd  = msd_v;
  assign cnt.tick = tick_q;
  assign cnt.wrap = wrap_q;

  logic unused_ok;
  assign unused_ok = msd_carry;

endmodule

// File: tb/tb_bcd_cnt_2digit.sv
// Scoreboard bench: two counters (terminal 99 and 59, DIV=2) checked against a decimal model.
module tb_bcd_cnt_2digit;

  localparam int DIV = 2;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  bcd_cnt_2digit_if ia ();
  bcd_cnt_2digit_if ib ();

  bcd_cnt_2digit #(.DIV(DIV), .MAX_BCD(8'h99)) dut_a (.clock(clock), .resetn(resetn), .cnt(ia.slave));
  bcd_cnt_2digit #(.DIV(DIV), .MAX_BCD(8'h59)) dut_b (.clock(clock), .resetn(resetn), .cnt(ib.slave));

  typedef struct {
    int a;
    bit wa;
    int b;
    bit wb;
    bit tk;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  int   pre   = 0;
  bit   mtick = 0;
  int   va    = 0;
  int   vb    = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int to_bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  function automatic void model(input int v, input int mx, input bit ld, input int lm, input int ll,
                                input bit en, input bit up, input bit tk,
                                output int nv, output bit w);
    int m, l;
    nv = v;
    w  = 1'b0;
    if (ld) begin
      m  = (lm > 9) ? 9 : lm;
      l  = (ll > 9) ? 9 : ll;
      nv = m * 10 + l;
      if (nv > mx) nv = mx;
    end else if (tk && en) begin
      if (up) begin
        if (v == mx) begin nv = 0; w = 1'b1; end
        else nv = v + 1;
      end else begin
        if (v == 0) begin nv = mx; w = 1'b1; end
        else nv = v - 1;
      end
    end
  endfunction

  // One clock: predict from current inputs, push, take the edge, pop and compare.
  task automatic cycle();
    exp_t e;
    exp_t got;
    e.tk = (pre == DIV - 1);
    model(va, 99, ia.load, int'(ia.load_msd), int'(ia.load_lsd), ia.en, ia.up, mtick, e.a, e.wa);
    model(vb, 59, ib.load, int'(ib.load_msd), int'(ib.load_lsd), ib.en, ib.up, mtick, e.b, e.wb);
    pre   = (pre == DIV - 1) ? 0 : pre + 1;
    mtick = e.tk;
    va    = e.a;
    vb    = e.b;
    sbq.push_back(e);
    @(posedge clock);
    #1;
    got = sbq.pop_front();
    chk("cnt_a",  int'({ia.msd, ia.lsd}), to_bcd(got.a));
    chk("wrap_a", int'(ia.wrap), int'(got.wa));
    chk("cnt_b",  int'({ib.msd, ib.lsd}), to_bcd(got.b));
    chk("wrap_b", int'(ib.wrap), int'(got.wb));
    chk("tick",   int'(ia.tick), int'(got.tk));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drive(input bit en, input bit up);
    ia.en = en; ib.en = en;
    ia.up = up; ib.up = up;
  endtask

  task automatic do_load(input logic [3:0] m, input logic [3:0] l);
    ia.load = 1'b1; ib.load = 1'b1;
    ia.load_msd = m; ib.load_msd = m;
    ia.load_lsd = l; ib.load_lsd = l;
    cycle();
    ia.load = 1'b0; ib.load = 1'b0;
  endtask

  task automatic until_tick_high();
    for (int i = 0; i < DIV + 1 && !mtick; i++) cycle();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a"}, int'({ia.msd, ia.lsd, 2'b00, ia.tick, ia.wrap}), 0);
    chk({tag, "_b"}, int'({ib.msd, ib.lsd, 2'b00, ib.tick, ib.wrap}), 0);
  endtask

  task automatic model_reset();
    pre = 0; mtick = 0; va = 0; vb = 0;
  endtask

  initial begin
    drive(1'b0, 1'b1);
    ia.load = 1'b0; ib.load = 1'b0;
    ia.load_msd = '0; ia.load_lsd = '0;
    ib.load_msd = '0; ib.load_lsd = '0;
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    resetn = 1'b1;
    model_reset();

    // First tick lands DIV cycles after release; checked inside cycle().
    cycles(4);

    // Up count from 08 through the decade carry.
    do_load(4'h0, 4'h8);
    drive(1'b1, 1'b1);
    cycles(6);

    // 98 -> 99 -> 00 wrap on the 99 counter; the 59 counter saturated its load.
    drive(1'b0, 1'b1);
    do_load(4'h9, 4'h8);
    drive(1'b1, 1'b1);
    cycles(6);

    // Down count: 10 -> 09, then 00 -> terminal with wrap.
    drive(1'b0, 1'b0);
    do_load(4'h1, 4'h0);
    drive(1'b1, 1'b0);
    cycles(3);
    drive(1'b0, 1'b0);
    do_load(4'h0, 4'h0);
    drive(1'b1, 1'b0);
    cycles(4);

    // Load clamping: non-BCD nibble, then pair above the terminal count.
    drive(1'b0, 1'b1);
    do_load(4'hC, 4'h3);
    cycles(2);
    do_load(4'h7, 4'h2);
    cycles(2);

    // Load coincident with tick wins; no step, no wrap.
    drive(1'b1, 1'b1);
    until_tick_high();
    do_load(4'h4, 4'h5);
    cycles(3);
    drive(1'b1, 1'b0);
    until_tick_high();
    do_load(4'hF, 4'hF);
    cycles(3);

    // Enable low across five ticks, then resume.
    drive(1'b0, 1'b1);
    cycles(5 * DIV);
    drive(1'b1, 1'b1);
    cycles(2 * DIV);

    // Randomised mix of enable, direction and loads.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) == 0) begin
        do_load(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end else begin
        cycle();
      end
    end

    // Asynchronous reset mid-count at 37, away from any edge.
    drive(1'b0, 1'b1);
    do_load(4'h3, 4'h7);
    cycles(1);
    #2;
    resetn = 1'b0;
    #1;
    check_zero("async_rst");
    @(posedge clock);
    #1;
    check_zero("rst_hold");
    resetn = 1'b1;
    model_reset();
    drive(1'b1, 1'b1);
    cycles(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
